rvfi_retire_checker: RTL

Consumer end of the core's RVFI retirement port: monitors every retired instruction, keeps a shadow architectural register file, and flags register-read, x0, PC-continuity, store-mask and liveness errors. Instantiated beside the core in simulation and FPGA debug builds. It drives nothing back into the pipeline.

---
 rtl/rvfi_pkg.sv | 29 ++
 rtl/rvfi_shadow_regfile.sv | 39 +++
 rtl/rvfi_retire_checker.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rvfi_pkg.sv
// Shared constants for the RVFI retirement checker: error codes, opcodes and FSM states.
package rvfi_pkg;

  localparam logic [3:0] ERR_NONE         = 4'd0;
  localparam logic [3:0] ERR_RS1_MISMATCH = 4'd1;
  localparam logic [3:0] ERR_RS2_MISMATCH = 4'd2;
  localparam logic [3:0] ERR_X0_WRITE     = 4'd3;
  localparam logic [3:0] ERR_PC_DISCONT   = 4'd4;
  localparam logic [3:0] ERR_PC_MISALIGN  = 4'd5;
  localparam logic [3:0] ERR_WMASK_BAD    = 4'd6;
  localparam logic [3:0] ERR_TIMEOUT      = 4'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    StWait,
    StRun,
    StFail
  } rvfi_state_e;

endpackage

// File: rtl/rvfi_shadow_regfile.sv
// Shadow architectural register file: two async read ports, one sync write port, x0 reads as 0.
module rvfi_shadow_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] mem_q [32];
  logic [31:0] mem_d [32];

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we && (waddr != 5'd0)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (rst) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : mem_q[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : mem_q[raddr_b];

endmodule

// File: rtl/rvfi_retire_checker.sv
// Passive RVFI retirement monitor: checks operands against a shadow regfile, PC flow,
// store masks and liveness, and latches the first error plus running counters.
module rvfi_retire_checker
  import rvfi_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rvfi_valid,
  input  logic [31:0]          rvfi_insn,
  input  logic [4:0]           rvfi_rs1_addr,
  input  logic [4:0]           rvfi_rs2_addr,
  input  logic [31:0]          rvfi_rs1_rdata,
  input  logic [31:0]          rvfi_rs2_rdata,
  input  logic [4:0]           rvfi_rd_addr,
  input  logic [31:0]          rvfi_rd_wdata,
  input  logic [31:0]          rvfi_pc_rdata,
  input  logic [31:0]          rvfi_pc_wdata,
  input  logic [31:0]          rvfi_mem_addr,
  input  logic [3:0]           rvfi_mem_wmask,
  input  logic [31:0]          rvfi_mem_rdata,
  input  logic [31:0]          rvfi_mem_wdata,
  output logic                 err,
  output logic [3:0]           err_code,
  output logic [31:0]          err_pc,
  output logic [31:0]          err_insn,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [31:0]          retire_count
);

  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  rvfi_state_e          state_q, state_d;
  logic                 err_q, err_d;
  logic [3:0]           err_code_q, err_code_d;
  logic [31:0]          err_pc_q, err_pc_d;
  logic [31:0]          err_insn_q, err_insn_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [31:0]          retire_count_q, retire_count_d;
  logic [IdleW-1:0]     idle_q, idle_d;
  logic [31:0]          pc_prev_q, pc_prev_d;

  logic [31:0] shadow_rs1, shadow_rs2;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        use_rs1, use_rs2, is_store, wmask_ok;
  logic [3:0]  ret_code;
  logic        retire_err, timeout_evt, capture;

  // Memory data/address are carried on the port but not checked.
  logic unused_mem;
  assign unused_mem = ^{rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata};

  rvfi_shadow_regfile u_shadow (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rvfi_rs1_addr),
    .rdata_a (shadow_rs1),
    .raddr_b (rvfi_rs2_addr),
    .rdata_b (shadow_rs2),
    .we      (rvfi_valid),
    .waddr   (rvfi_rd_addr),
    .wdata   (rvfi_rd_wdata)
  );

  assign opcode = rvfi_insn[6:0];
  assign funct3 = rvfi_insn[14:12];

  always_comb begin
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    is_store = 1'b0;
    unique case (opcode)
      OP_R:                        begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_IMM, OP_LOAD, OP_JALR:    use_rs1 = 1'b1;
      OP_STORE:                    begin use_rs1 = 1'b1; use_rs2 = 1'b1; is_store = 1'b1; end
      OP_BRANCH:                   begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      default:                     ;
    endcase
  end

  always_comb begin
    wmask_ok = (rvfi_mem_wmask == 4'b0000);
    if (is_store) begin
      unique case (funct3)
        3'b000:  wmask_ok = $onehot(rvfi_mem_wmask);
        3'b001:  wmask_ok = (rvfi_mem_wmask == 4'b0011) || (rvfi_mem_wmask == 4'b1100);
        3'b010:  wmask_ok = (rvfi_mem_wmask == 4'b1111);
        default: wmask_ok = 1'b0;
      endcase
    end
  end

  // Lowest code wins when several checks fire on one retirement.
  always_comb begin
    ret_code = ERR_NONE;
    if (use_rs1 && (rvfi_rs1_rdata != shadow_rs1)) begin
      ret_code = ERR_RS1_MISMATCH;
    end else if (use_rs2 && (rvfi_rs2_rdata != shadow_rs2)) begin
      ret_code = ERR_RS2_MISMATCH;
    end else if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0)) begin
      ret_code = ERR_X0_WRITE;
    end else if ((state_q != StWait) && (rvfi_pc_rdata != pc_prev_q)) begin
      ret_code = ERR_PC_DISCONT;
    end else if (rvfi_pc_wdata[1:0] != 2'b00) begin
      ret_code = ERR_PC_MISALIGN;
    end else if (!wmask_ok) begin
      ret_code = ERR_WMASK_BAD;
    end
  end

  assign retire_err  = rvfi_valid && (ret_code != ERR_NONE);
  assign timeout_evt = (state_q == StRun) && !rvfi_valid && (idle_q == IdleW'(TIMEOUT));

  always_comb begin
    state_d        = state_q;
    capture        = 1'b0;
    err_d          = err_q;
    err_code_d     = err_code_q;
    err_pc_d       = err_pc_q;
    err_insn_d     = err_insn_q;
    err_count_d    = err_count_q;
    retire_count_d = retire_count_q;
    idle_d         = idle_q;
    pc_prev_d      = pc_prev_q;

    unique case (state_q)
      StWait: begin
        if (rvfi_valid) begin
          state_d = retire_err ? StFail : StRun;
          capture = retire_err;
        end
      end
      StRun: begin
        if (retire_err || timeout_evt) begin
          state_d = StFail;
          capture = 1'b1;
        end
      end
      default: ;
    endcase

    if (capture) begin
      err_d      = 1'b1;
      err_code_d = timeout_evt ? ERR_TIMEOUT : ret_code;
      err_pc_d   = timeout_evt ? pc_prev_q : rvfi_pc_rdata;
      err_insn_d = timeout_evt ? 32'd0 : rvfi_insn;
    end

    if ((retire_err || timeout_evt) && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end

    if (rvfi_valid) begin
      retire_count_d = retire_count_q + 32'd1;
      pc_prev_d      = rvfi_pc_wdata;
      idle_d         = '0;
    end else if (state_q == StRun) begin
      idle_d = timeout_evt ? '0 : idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StWait;
      err_q          <= 1'b0;
      err_code_q     <= ERR_NONE;
      err_pc_q       <= '0;
      err_insn_q     <= '0;
      err_count_q    <= '0;
      retire_count_q <= '0;
      idle_q         <= '0;
      pc_prev_q      <= '0;
    end else begin
      state_q        <= state_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
      err_pc_q       <= err_pc_d;
      err_insn_q     <= err_insn_d;
      err_count_q    <= err_count_d;
      retire_count_q <= retire_count_d;
      idle_q         <= idle_d;
      pc_prev_q      <= pc_prev_d;
    end
  end

  assign err          = err_q;
  assign err_code     = err_code_q;
  assign err_pc       = err_pc_q;
  assign err_insn     = err_insn_q;
  assign err_count    = err_count_q;
  assign retire_count = retire_count_q;

endmodule
